bram_line_reader: RTL

// Fetch engine on the read side of the 36-bit line-store block RAM (port A, DOA_REG=1).
// On a start command it streams WORDS consecutive 36-bit words out of the RAM and

---
 rtl/bram_line_reader.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/bram_line_reader.sv
// bram_line_reader
// Read-side fetch engine for the 36-bit line-store block RAM. A start command
// streams a run of consecutive words out of RAM port A. Each word is split into
// four 9-bit {parity, byte} pixels, low byte first, on a valid/ready stream.
// Reads are only issued while the word buffer has room for everything in flight.
module bram_line_reader #(
  parameter int ADDR_WIDTH = 9,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   words,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [35:0]           ram_do,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic [8:0]            pix_data
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int OCC_W  = $clog2(FIFO_DEPTH + RD_LATENCY + 2) + 1;
  localparam int WCNT_W = ADDR_WIDTH + 1;
  localparam int PIX_W  = ADDR_WIDTH + 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                state_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  ram_en_r;
  logic [ADDR_WIDTH-1:0] ram_addr_r;
  logic                  pix_valid_r;
  logic [8:0]            pix_data_r;
  logic [WCNT_W-1:0]     rem_r;        // reads not yet placed on ram_en
  logic [PIX_W-1:0]      pix_left_r;   // pixel handshakes still owed
  logic [RD_LATENCY-1:0] pipe_r;       // one bit per read still inside the RAM
  logic [35:0]           fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [1:0]            lane_r;       // lane of the pixel currently presented

  logic                  hs_s;
  logic                  pop_s;
  logic                  wr_s;
  logic                  flush_s;
  logic                  issue_s;
  logic                  src_ok_s;
  logic [35:0]           src_word_s;
  logic [1:0]            lane_n_s;
  logic [OCC_W-1:0]      occ_s;
  logic [PTR_W-1:0]      head_s;
  logic [CNT_W-1:0]      cnt_pop_s;

  // Select pixel 'lane' of a RAM word: {parity bit of that byte, byte}.
  function automatic logic [8:0] lane_pixel(input logic [35:0] word, input logic [1:0] lane);
    case (lane)
      2'd0:    lane_pixel = {word[32], word[7:0]};
      2'd1:    lane_pixel = {word[33], word[15:8]};
      2'd2:    lane_pixel = {word[34], word[23:16]};
      2'd3:    lane_pixel = {word[35], word[31:24]};
      default: lane_pixel = 9'd0;
    endcase
  endfunction

  // Handshake, buffer occupancy, issue decision and the next word for the output stage.
  always_comb begin
    hs_s      = pix_valid_r && pix_ready;
    pop_s     = hs_s && (lane_r == 2'd3);
    wr_s      = pipe_r[RD_LATENCY-1];
    flush_s   = abort && busy_r;
    lane_n_s  = hs_s ? (lane_r + 2'd1) : lane_r;
    head_s    = rd_ptr_r + PTR_W'(pop_s);
    cnt_pop_s = cnt_r - CNT_W'(pop_s);
    // Occupancy as it will stand next cycle: buffered words, the read on the
    // port now and reads inside the RAM, less the word popped at this edge.
    occ_s = OCC_W'(cnt_r) + OCC_W'(ram_en_r);
    for (int i = 0; i < RD_LATENCY; i++) begin
      occ_s = occ_s + OCC_W'(pipe_r[i]);
    end
    occ_s   = occ_s - OCC_W'(pop_s);
    issue_s = (state_r == ST_FETCH) && (rem_r != '0) && (occ_s < OCC_W'(FIFO_DEPTH));
    // An empty buffer is bypassed so the arriving word reaches the pixel register directly.
    if (cnt_pop_s != '0) begin
      src_ok_s   = 1'b1;
      src_word_s = fifo_mem_r[head_s];
    end else if (wr_s) begin
      src_ok_s   = 1'b1;
      src_word_s = ram_do;
    end else begin
      src_ok_s   = 1'b0;
      src_word_s = 36'd0;
    end
  end

  // Word buffer storage; pointers and count live in the control block.
  always_ff @(posedge clock) begin
    if (wr_s) begin
      fifo_mem_r[wr_ptr_r] <= ram_do;
    end
  end

  // Line FSM, read issue, buffer pointers and registered pixel output.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      ram_en_r    <= 1'b0;
      ram_addr_r  <= '0;
      pix_valid_r <= 1'b0;
      pix_data_r  <= 9'd0;
      rem_r       <= '0;
      pix_left_r  <= '0;
      pipe_r      <= '0;
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      cnt_r       <= '0;
      lane_r      <= 2'd0;
    end else begin
      done_r     <= 1'b0;
      ram_addr_r <= ram_addr_r + ADDR_WIDTH'(ram_en_r);
      pix_left_r <= pix_left_r - PIX_W'(hs_s);
      pipe_r[0]  <= ram_en_r;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
      wr_ptr_r <= wr_ptr_r + PTR_W'(wr_s);
      rd_ptr_r <= rd_ptr_r + PTR_W'(pop_s);
      cnt_r    <= cnt_r + CNT_W'(wr_s) - CNT_W'(pop_s);
      lane_r   <= lane_n_s;
      if (pix_valid_r && !pix_ready) begin
        pix_valid_r <= 1'b1;
      end else if (src_ok_s) begin
        pix_valid_r <= 1'b1;
        pix_data_r  <= lane_pixel(src_word_s, lane_n_s);
      end else begin
        pix_valid_r <= 1'b0;
      end

      case (state_r)
        ST_IDLE: begin
          if (start) begin
            busy_r     <= 1'b1;
            ram_addr_r <= base_addr;
            pix_left_r <= {words, 2'b00};
            if (words != '0) begin
              state_r  <= ST_FETCH;
              ram_en_r <= 1'b1;
              rem_r    <= words - WCNT_W'(1);
            end else begin
              state_r  <= ST_DRAIN;
              ram_en_r <= 1'b0;
              rem_r    <= '0;
            end
          end else begin
            ram_en_r <= 1'b0;
          end
        end
        ST_FETCH: begin
          ram_en_r <= issue_s;
          rem_r    <= rem_r - WCNT_W'(issue_s);
          // rem_r == 0 here means the port is carrying the final read.
          if (rem_r == '0) begin
            state_r <= ST_DRAIN;
          end else begin
            state_r <= ST_FETCH;
          end
        end
        ST_DRAIN: begin
          ram_en_r <= 1'b0;
          if ((pix_left_r == '0) || (hs_s && (pix_left_r == PIX_W'(1)))) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          busy_r   <= 1'b0;
          ram_en_r <= 1'b0;
        end
      endcase

      // Abort discards everything: data still returning from the RAM is
      // dropped because its pipe bits are cleared.
      if (flush_s) begin
        state_r     <= ST_IDLE;
        busy_r      <= 1'b0;
        done_r      <= 1'b1;
        ram_en_r    <= 1'b0;
        rem_r       <= '0;
        pix_left_r  <= '0;
        pipe_r      <= '0;
        wr_ptr_r    <= '0;
        rd_ptr_r    <= '0;
        cnt_r       <= '0;
        lane_r      <= 2'd0;
        pix_valid_r <= 1'b0;
        pix_data_r  <= 9'd0;
      end
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign ram_en    = ram_en_r;
  assign ram_addr  = ram_addr_r;
  assign pix_valid = pix_valid_r;
  assign pix_data  = pix_data_r;

endmodule
